// File: rtl/dual_port_ram_param.sv
// dual_port_ram_param: parametrised synchronous true dual-port RAM.
// Two independent read/write ports on one clock, registered reads with
// selectable read-during-write behaviour (READ_MODE) and an optional extra
// output stage (OUT_REG). After every reset an INIT sweep writes zero to every
// word before the ports are served. Same-address write-write collisions are
// resolved in favour of port A and flagged on the collision output.
// Optional feature macro: DPRAM_COLL_CNT_EN adds the saturating coll_cnt port.
module dual_port_ram_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024,
    parameter int READ_MODE = 0,
    parameter int OUT_REG   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    input  logic              en_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic [DATA_W-1:0] dout_a,
    output logic [DATA_W-1:0] dout_b,
    output logic              vld_a,
    output logic              vld_b,
    output logic              init_done,
    output logic              collision
`ifdef DPRAM_COLL_CNT_EN
    ,
    output logic [15:0]       coll_cnt
`endif
);

    localparam logic [0:0]        INIT      = 1'b0;
    localparam logic [0:0]        READY     = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic              ready;
    logic              in_range_a;
    logic              in_range_b;
    logic              acc_a;
    logic              acc_b;
    logic              wr_a;
    logic              wr_b;
    logic              same_addr;
    logic              coll_now;
    logic [DATA_W-1:0] rd_next_a;
    logic [DATA_W-1:0] rd_next_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              rd_vld_a;
    logic              rd_vld_b;

    assign ready      = (state == READY);
    assign init_done  = ready;
    assign in_range_a = ({1'b0, addr_a} < DEPTH_W);
    assign in_range_b = ({1'b0, addr_b} < DEPTH_W);
    assign same_addr  = (addr_a == addr_b);
    assign acc_a      = ready & en_a;
    assign acc_b      = ready & en_b;
    assign wr_a       = acc_a & we_a & in_range_a;
    // Port A wins a same-address write-write collision, so B is suppressed
    assign coll_now   = wr_a & acc_b & we_b & in_range_b & same_addr;
    assign wr_b       = acc_b & we_b & in_range_b & ~coll_now;

    // Sweep pointer and INIT -> READY sequencing; reset restarts the sweep at 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            ptr   <= '0;
        end else if (state == INIT) begin
            if (ptr == LAST_ADDR) begin
                state <= READY;
            end else begin
                ptr <= ptr + 1'b1;
            end
        end
    end

    // Array writes: zero fill during INIT, port writes once READY
    always_ff @(posedge clk) begin
        if (!ready) begin
            mem[ptr] <= '0;
        end else begin
            if (wr_a) begin
                mem[addr_a] <= din_a;
            end
            if (wr_b) begin
                mem[addr_b] <= din_b;
            end
        end
    end

    // Port A read word: zero out of range, din when write-first, else old word
    always_comb begin
        rd_next_a = '0;
        if (in_range_a) begin
            if (READ_MODE != 0 && we_a) begin
                rd_next_a = din_a;
            end else begin
                rd_next_a = mem[addr_a];
            end
        end
    end

    // Port B read word: same rules as A, using B's own write data
    always_comb begin
        rd_next_b = '0;
        if (in_range_b) begin
            if (READ_MODE != 0 && we_b) begin
                rd_next_b = din_b;
            end else begin
                rd_next_b = mem[addr_b];
            end
        end
    end

    // First read stage: capture data per accepted access, data holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
            rd_vld_a  <= 1'b0;
            rd_vld_b  <= 1'b0;
        end else begin
            rd_vld_a <= acc_a;
            rd_vld_b <= acc_b;
            if (acc_a) begin
                rd_data_a <= rd_next_a;
            end
            if (acc_b) begin
                rd_data_b <= rd_next_b;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] dout_a_q;
            logic [DATA_W-1:0] dout_b_q;
            logic              vld_a_q;
            logic              vld_b_q;

            // Optional second stage: forwards the first stage one cycle later
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_a_q <= '0;
                    dout_b_q <= '0;
                    vld_a_q  <= 1'b0;
                    vld_b_q  <= 1'b0;
                end else begin
                    vld_a_q <= rd_vld_a;
                    vld_b_q <= rd_vld_b;
                    if (rd_vld_a) begin
                        dout_a_q <= rd_data_a;
                    end
                    if (rd_vld_b) begin
                        dout_b_q <= rd_data_b;
                    end
                end
            end

            assign dout_a = dout_a_q;
            assign dout_b = dout_b_q;
            assign vld_a  = vld_a_q;
            assign vld_b  = vld_b_q;
        end else begin : g_no_out_reg
            assign dout_a = rd_data_a;
            assign dout_b = rd_data_b;
            assign vld_a  = rd_vld_a;
            assign vld_b  = rd_vld_b;
        end
    endgenerate

    // Registered one-cycle collision pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collision <= 1'b0;
        end else begin
            collision <= coll_now;
        end
    end

`ifdef DPRAM_COLL_CNT_EN
    // Saturating count of collision pulses, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_cnt <= '0;
        end else if (collision && coll_cnt != 16'hFFFF) begin
            coll_cnt <= coll_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dual_port_ram_param.sv
// tb_dual_port_ram_param: scoreboard bench for dual_port_ram_param.
// Two instances share the same stimulus: inst 0 is read-first without the
// output stage, inst 1 is write-first with the output stage. A reference
// model predicts each read response and pushes it with its due cycle; a
// negedge monitor pops and compares whenever a DUT presents vld/collision.
module tb_dual_port_ram_param;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1000;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en_a = 1'b0;
    logic              we_a = 1'b0;
    logic [ADDR_W-1:0] addr_a = '0;
    logic [DATA_W-1:0] din_a = '0;
    logic              en_b = 1'b0;
    logic              we_b = 1'b0;
    logic [ADDR_W-1:0] addr_b = '0;
    logic [DATA_W-1:0] din_b = '0;

    logic [DATA_W-1:0] dout_a0, dout_b0, dout_a1, dout_b1;
    logic              vld_a0, vld_b0, vld_a1, vld_b1;
    logic              init_done0, init_done1;
    logic              collision0, collision1;
`ifdef DPRAM_COLL_CNT_EN
    logic [15:0]       coll_cnt0, coll_cnt1;
`endif

    int                cyc = 0;
    int                rel_cyc = 0;
    bit                in_reset = 1'b1;
    int                tests = 0;
    int                fails = 0;
    int                model_cc = 0;
    logic [DATA_W-1:0] model_mem [DEPTH];
    exp_t              exp_q [4][$];
    int                coll_q [2][$];

    dual_port_ram_param #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_MODE(0), .OUT_REG(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
        .dout_a(dout_a0), .dout_b(dout_b0), .vld_a(vld_a0), .vld_b(vld_b0),
        .init_done(init_done0), .collision(collision0)
`ifdef DPRAM_COLL_CNT_EN
        , .coll_cnt(coll_cnt0)
`endif
    );

    dual_port_ram_param #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_MODE(1), .OUT_REG(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
        .dout_a(dout_a1), .dout_b(dout_b1), .vld_a(vld_a1), .vld_b(vld_b1),
        .init_done(init_done1), .collision(collision1)
`ifdef DPRAM_COLL_CNT_EN
        , .coll_cnt(coll_cnt1)
`endif
    );

    // 10 ns clock and a cycle counter stepped on every rising edge
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference read: out-of-range is 0, write-first returns din, else the stored word
    function automatic logic [DATA_W-1:0] model_read(input int inst, input logic [ADDR_W-1:0] a,
                                                     input logic w, input logic [DATA_W-1:0] d);
        if (int'(a) >= DEPTH) return '0;
        if (w && inst == 1) return d;
        return model_mem[a];
    endfunction

    function automatic logic [ADDR_W-1:0] pick_addr();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return ADDR_W'($urandom_range(DEPTH, 1023));
        if (r < 4) return ADDR_W'($urandom_range(0, DEPTH - 1));
        return ADDR_W'(990 + $urandom_range(0, 9));
    endfunction

    // Drive one cycle of requests and push the model's expected responses
    task automatic applyStimulus(input logic ea, input logic wa, input logic [ADDR_W-1:0] aa,
                                 input logic [DATA_W-1:0] da, input logic eb, input logic wb,
                                 input logic [ADDR_W-1:0] ab, input logic [DATA_W-1:0] db);
        exp_t e;
        bit   a_wrote;
        @(posedge clk);
        #1;
        en_a = ea; we_a = wa; addr_a = aa; din_a = da;
        en_b = eb; we_b = wb; addr_b = ab; din_b = db;
        if (!in_reset && (cyc - rel_cyc) >= DEPTH) begin
            for (int inst = 0; inst < 2; inst++) begin
                if (ea) begin
                    e.data = model_read(inst, aa, wa, da);
                    e.due  = cyc + inst + 1;
                    exp_q[inst*2].push_back(e);
                end
                if (eb) begin
                    e.data = model_read(inst, ab, wb, db);
                    e.due  = cyc + inst + 1;
                    exp_q[inst*2+1].push_back(e);
                end
            end
            a_wrote = ea && wa && int'(aa) < DEPTH;
            if (a_wrote) model_mem[aa] = da;
            if (eb && wb && int'(ab) < DEPTH) begin
                if (a_wrote && aa == ab) begin
                    coll_q[0].push_back(cyc + 1);
                    coll_q[1].push_back(cyc + 1);
                    if (model_cc < 16'hFFFF) model_cc++;
                end else begin
                    model_mem[ab] = db;
                end
            end
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    // Compare one port's output against the front of its expectation queue
    task automatic checkOutput(input int id, input logic vld, input logic [DATA_W-1:0] dout);
        exp_t e;
        if (vld) begin
            tests++;
            if (exp_q[id].size() == 0) begin
                fails++;
                $display("[TB] FAIL rd%0d cycle %0d: got vld=1 data=%0d, required no response", id, cyc, dout);
            end else begin
                e = exp_q[id].pop_front();
                if (dout !== e.data || e.due != cyc) begin
                    fails++;
                    $display("[TB] FAIL rd%0d cycle %0d: got data=%0d, required data=%0d due cycle %0d",
                             id, cyc, dout, e.data, e.due);
                end
            end
        end else if (exp_q[id].size() > 0 && exp_q[id][0].due <= cyc) begin
            tests++;
            fails++;
            e = exp_q[id].pop_front();
            $display("[TB] FAIL rd%0d cycle %0d: got vld=0, required vld=1 data=%0d", id, cyc, e.data);
        end
    endtask

    task automatic checkCollision(input int inst, input logic coll);
        int due;
        if (coll) begin
            tests++;
            if (coll_q[inst].size() == 0) begin
                fails++;
                $display("[TB] FAIL coll%0d cycle %0d: got collision=1, required 0", inst, cyc);
            end else begin
                due = coll_q[inst].pop_front();
                if (due != cyc) begin
                    fails++;
                    $display("[TB] FAIL coll%0d cycle %0d: got pulse, required pulse at cycle %0d", inst, cyc, due);
                end
            end
        end else if (coll_q[inst].size() > 0 && coll_q[inst][0] <= cyc) begin
            tests++;
            fails++;
            due = coll_q[inst].pop_front();
            $display("[TB] FAIL coll%0d cycle %0d: got collision=0, required 1", inst, cyc);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic checkCollCount();
`ifdef DPRAM_COLL_CNT_EN
        checkValue("coll_cnt0", int'(coll_cnt0), model_cc);
        checkValue("coll_cnt1", int'(coll_cnt1), model_cc);
`endif
    endtask

    // Monitor: all response, collision and init_done checks on the falling edge
    always @(negedge clk) begin
        bit want_init;
        checkOutput(0, vld_a0, dout_a0);
        checkOutput(1, vld_b0, dout_b0);
        checkOutput(2, vld_a1, dout_a1);
        checkOutput(3, vld_b1, dout_b1);
        checkCollision(0, collision0);
        checkCollision(1, collision1);
        want_init = !in_reset && (cyc - rel_cyc) >= DEPTH;
        checkValue("init_done0", int'(init_done0), int'(want_init));
        checkValue("init_done1", int'(init_done1), int'(want_init));
    end

    // Assert reset mid-cycle, check outputs clear at once, then release
    task automatic resetDut();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        in_reset = 1'b1;
        en_a = 1'b0; en_b = 1'b0;
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        coll_q[0].delete();
        coll_q[1].delete();
        model_cc = 0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        #1;
        checkValue("rst dout", int'({dout_a0, dout_b0, dout_a1, dout_b1}), 0);
        checkValue("rst vld", int'({vld_a0, vld_b0, vld_a1, vld_b1}), 0);
        checkValue("rst flags", int'({init_done0, init_done1, collision0, collision1}), 0);
        checkCollCount();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_reset = 1'b0;
        rel_cyc = cyc;
    endtask

    // Requests issued during the sweep must be dropped without a vld pulse
    task automatic sweepWithTraffic();
        while ((cyc - rel_cyc) < DEPTH - 1) begin
            applyStimulus(1, 1'($urandom_range(0, 1)), pick_addr(), 8'($urandom),
                          1, 1'($urandom_range(0, 1)), pick_addr(), 8'($urandom));
            @(negedge clk);
            tests++;
            if ({vld_a0, vld_b0, vld_a1, vld_b1} != 4'b0) begin
                fails++;
                $display("[TB] FAIL init vld cycle %0d: got %b, required 0000", cyc,
                         {vld_a0, vld_b0, vld_a1, vld_b1});
            end
        end
        idleCycles(1);
    endtask

    initial begin
        #1;
        resetDut();
        sweepWithTraffic();

        // Fresh array reads back zero, including an out-of-range read
        applyStimulus(1, 0, 10'd901, 8'd0, 1, 0, 10'd910, 8'd0);
        applyStimulus(1, 0, 10'd999, 8'd0, 1, 0, 10'd1001, 8'd0);

        // Dual write then cross reads
        applyStimulus(1, 1, 10'd901, 8'd210, 1, 1, 10'd888, 8'd110);
        applyStimulus(1, 0, 10'd888, 8'd0, 1, 0, 10'd901, 8'd0);

        // Read during write on A, B reads the same word in that cycle
        applyStimulus(1, 1, 10'd777, 8'd109, 0, 0, '0, '0);
        applyStimulus(1, 1, 10'd777, 8'd140, 1, 0, 10'd777, 8'd0);
        applyStimulus(1, 0, 10'd777, 8'd0, 0, 0, '0, '0);

        // Three write-write collisions, each followed by a read of the word
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 10'd999, 8'd100, 1, 1, 10'd999, 8'd250);
            applyStimulus(1, 0, 10'd999, 8'd0, 1, 0, 10'd999, 8'd0);
        end
        idleCycles(4);
        checkCollCount();

        // Out-of-range writes are ignored and must not alias low addresses
        applyStimulus(1, 1, 10'd1005, 8'd55, 1, 1, 10'd1020, 8'd66);
        applyStimulus(1, 0, 10'd1005, 8'd0, 1, 0, 10'd5, 8'd0);
        applyStimulus(1, 0, 10'd20, 8'd0, 0, 0, '0, '0);

        // Random traffic concentrated on a small window to force collisions
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), pick_addr(), 8'($urandom),
                          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), pick_addr(), 8'($urandom));
        end
        idleCycles(4);
        checkCollCount();

        // Reset while an OUT_REG read is in flight: response must vanish
        applyStimulus(1, 0, 10'd901, 8'd0, 1, 0, 10'd888, 8'd0);
        resetDut();
        idleCycles(3);
        sweepWithTraffic();
        applyStimulus(1, 0, 10'd901, 8'd0, 1, 0, 10'd888, 8'd0);
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_addr(), 8'($urandom),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_addr(), 8'($urandom));
        end
        idleCycles(4);
        checkCollCount();

        for (int i = 0; i < 4; i++) checkValue($sformatf("leftover rd%0d", i), exp_q[i].size(), 0);
        checkValue("leftover coll", coll_q[0].size() + coll_q[1].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
